// File: rtl/keypad_event_port_if.sv
// Keypad event port bus: scanner strobe/code and CPU read side.
// master = scanner/CPU side driving press, data and key_ack; slave = the event port.
interface keypad_event_port_if;
    logic       press;
    logic [3:0] data;
    logic       key_ack;
    logic [7:0] key_code;
    logic       key_valid;
    logic       interrupt;
    logic       overrun;

    modport master (
        output press,
        output data,
        output key_ack,
        input  key_code,
        input  key_valid,
        input  interrupt,
        input  overrun
    );

    modport slave (
        input  press,
        input  data,
        input  key_ack,
        output key_code,
        output key_valid,
        output interrupt,
        output overrun
    );
endinterface

// File: rtl/keypad_event_port.sv
// Keypad event port: debounces scanner strobes into accepted key events and
// presents them to the CPU as a one-entry register with valid, interrupt and overrun.
// Both parameters are expected to be at least 1.
module keypad_event_port #(
    parameter int unsigned DEB_COUNT  = 8,
    parameter int unsigned REL_CYCLES = 16
) (
    input logic               clk,
    input logic               rst,
    keypad_event_port_if.slave bus
);

    localparam int unsigned CntW = $clog2(DEB_COUNT + 1);
    localparam int unsigned GapW = $clog2(REL_CYCLES + 1);

    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEB_COUNT - 1);
    localparam logic [GapW-1:0] GapMax  = GapW'(REL_CYCLES);
    localparam logic [GapW-1:0] GapLast = GapW'(REL_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StHeld
    } state_e;

    state_e          state_q;
    logic [3:0]      cand_q;
    logic [CntW-1:0] count_q;
    logic [GapW-1:0] gap_q;

    logic [7:0]      key_code_q;
    logic            key_valid_q;
    logic            interrupt_q;
    logic            overrun_q;

    logic            match;
    logic            gap_release;
    logic            accept;
    logic            load_new;

    // A strobe carrying the same code as the current candidate.
    assign match = bus.press && (bus.data == cand_q);

    // This edge would bring the gap counter up to REL_CYCLES: the key has been let go.
    assign gap_release = !bus.press && (gap_q >= GapLast);

    // Accept event: the strobe that completes DEB_COUNT matching pulses.
    always_comb begin
        accept = 1'b0;
        unique case (state_q)
            StIdle:     accept = bus.press && (DEB_COUNT == 1);
            StDebounce: accept = match && (count_q == CntLast);
            default:    accept = 1'b0;
        endcase
    end

    // A new key is loaded unless an unread key would be overwritten (ack frees the slot).
    assign load_new = accept && (!key_valid_q || bus.key_ack);

    // Gap counter: cycles since the last strobe, saturating at REL_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_q <= GapMax;
        end else if (bus.press) begin
            gap_q <= '0;
        end else if (gap_q != GapMax) begin
            gap_q <= gap_q + 1'b1;
        end
    end

    // Debounce FSM: track candidate code and match count, hold off until release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cand_q  <= 4'h0;
            count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.press) begin
                        cand_q  <= bus.data;
                        count_q <= CntOne;
                        state_q <= accept ? StHeld : StDebounce;
                    end
                end
                StDebounce: begin
                    if (accept) begin
                        count_q <= '0;
                        state_q <= StHeld;
                    end else if (match) begin
                        count_q <= count_q + 1'b1;
                    end else if (bus.press) begin
                        // Code changed under the finger: restart on the new code.
                        cand_q  <= bus.data;
                        count_q <= CntOne;
                    end else if (gap_release) begin
                        cand_q  <= 4'h0;
                        count_q <= '0;
                        state_q <= StIdle;
                    end
                end
                StHeld: begin
                    if (gap_release) begin
                        cand_q  <= 4'h0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // CPU-facing register: load on accept, flag overrun, clear valid on ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code_q  <= 8'h00;
            key_valid_q <= 1'b0;
            interrupt_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            interrupt_q <= 1'b0;
            if (load_new) begin
                // On accept the strobe code always equals the candidate.
                key_code_q  <= {4'h0, bus.data};
                key_valid_q <= 1'b1;
                interrupt_q <= 1'b1;
                overrun_q   <= 1'b0;
            end else if (accept) begin
                overrun_q <= 1'b1;
            end else if (bus.key_ack && key_valid_q) begin
                key_valid_q <= 1'b0;
                overrun_q   <= 1'b0;
            end
        end
    end

    assign bus.key_code  = key_code_q;
    assign bus.key_valid = key_valid_q;
    assign bus.interrupt = interrupt_q;
    assign bus.overrun   = overrun_q;

    // An interrupt or overrun always refers to a key that is still unread.
    a_intr_valid : assert property (@(posedge clk) disable iff (rst)
        bus.interrupt |-> bus.key_valid);
    a_ovr_valid : assert property (@(posedge clk) disable iff (rst)
        bus.overrun |-> bus.key_valid);

endmodule

// File: tb/tb_keypad_event_port.sv
// Directed bench for keypad_event_port: inputs change and outputs are sampled on negedge.
module tb_keypad_event_port;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   intr_cnt = 0;
    int   ic0;

    keypad_event_port_if bus ();

    keypad_event_port #(
        .DEB_COUNT (8),
        .REL_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Count interrupt pulses, one per clock the line is high.
    always @(posedge clk) begin
        if (bus.interrupt) intr_cnt <= intr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs; returns at the following negedge with outputs settled.
    task automatic cyc(input logic p, input logic [3:0] d, input logic a);
        bus.press   = p;
        bus.data    = d;
        bus.key_ack = a;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 4'h0, 1'b0);
    endtask

    // n strobes of code d, each followed by gap idle cycles.
    task automatic pulses(input int n, input logic [3:0] d, input int gap);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, d, 1'b0);
            idle(gap);
        end
    endtask

    initial begin
        bus.press   = 1'b0;
        bus.data    = 4'h0;
        bus.key_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_code",  32'(bus.key_code),  32'h00);
        check("rst_valid", 32'(bus.key_valid), 32'h0);
        check("rst_intr",  32'(bus.interrupt), 32'h0);
        check("rst_ovr",   32'(bus.overrun),   32'h0);
        rst = 1'b0;
        idle(2);

        // Ack with nothing pending is ignored.
        cyc(1'b0, 4'h0, 1'b1);
        check("ack_idle_valid", 32'(bus.key_valid), 32'h0);
        check("ack_idle_ovr",   32'(bus.overrun),   32'h0);

        // Eight strobes of 5 accept on the eighth; interrupt for one cycle.
        pulses(7, 4'h5, 3);
        check("a5_pre_valid", 32'(bus.key_valid), 32'h0);
        cyc(1'b1, 4'h5, 1'b0);
        check("a5_code",  32'(bus.key_code),  32'h05);
        check("a5_valid", 32'(bus.key_valid), 32'h1);
        check("a5_intr",  32'(bus.interrupt), 32'h1);
        idle(1);
        check("a5_intr_off", 32'(bus.interrupt), 32'h0);
        cyc(1'b0, 4'h0, 1'b1);
        check("a5_ack_valid", 32'(bus.key_valid), 32'h0);
        check("a5_code_kept", 32'(bus.key_code),  32'h05);
        idle(20);

        // Held for 200 cycles then released: exactly one interrupt.
        ic0 = intr_cnt;
        pulses(50, 4'h5, 3);
        idle(20);
        check("hold_intr", 32'(intr_cnt - ic0), 32'd1);
        cyc(1'b0, 4'h0, 1'b1);
        // Back in idle: a fresh key is accepted again.
        pulses(8, 4'h3, 3);
        check("hold_next_code", 32'(bus.key_code), 32'h03);
        check("hold_next_intr", 32'(intr_cnt - ic0), 32'd2);
        cyc(1'b0, 4'h0, 1'b1);
        idle(20);

        // Code change mid-debounce restarts the count on the new code.
        ic0 = intr_cnt;
        pulses(3, 4'h5, 3);
        pulses(7, 4'h6, 3);
        check("chg_pre_valid", 32'(bus.key_valid), 32'h0);
        cyc(1'b1, 4'h6, 1'b0);
        check("chg_code", 32'(bus.key_code), 32'h06);
        idle(5);
        check("chg_intr", 32'(intr_cnt - ic0), 32'd1);
        cyc(1'b0, 4'h0, 1'b1);
        idle(20);

        // 12-cycle gap keeps the count.
        pulses(4, 4'h2, 3);
        idle(9);
        pulses(4, 4'h2, 3);
        check("gap12_code",  32'(bus.key_code),  32'h02);
        check("gap12_valid", 32'(bus.key_valid), 32'h1);
        cyc(1'b0, 4'h0, 1'b1);
        idle(20);

        // 16-cycle gap abandons the candidate.
        ic0 = intr_cnt;
        pulses(4, 4'h2, 3);
        idle(13);
        pulses(4, 4'h2, 3);
        check("gap16_valid", 32'(bus.key_valid), 32'h0);
        check("gap16_intr",  32'(intr_cnt - ic0), 32'd0);
        idle(20);

        // Second key while unread: overrun, code kept, single interrupt.
        ic0 = intr_cnt;
        pulses(8, 4'h5, 3);
        idle(20);
        pulses(8, 4'h9, 3);
        check("ovr_code", 32'(bus.key_code), 32'h05);
        check("ovr_flag", 32'(bus.overrun),  32'h1);
        check("ovr_intr", 32'(intr_cnt - ic0), 32'd1);
        cyc(1'b0, 4'h0, 1'b1);
        check("ovr_ack_valid", 32'(bus.key_valid), 32'h0);
        check("ovr_ack_flag",  32'(bus.overrun),   32'h0);
        idle(20);

        // Ack and accept on the same edge: new key loaded, overrun cleared.
        pulses(8, 4'h1, 3);
        idle(20);
        pulses(8, 4'h8, 3);
        check("same_pre_ovr", 32'(bus.overrun), 32'h1);
        idle(20);
        pulses(7, 4'h4, 3);
        cyc(1'b1, 4'h4, 1'b1);
        check("same_code",  32'(bus.key_code),  32'h04);
        check("same_valid", 32'(bus.key_valid), 32'h1);
        check("same_intr",  32'(bus.interrupt), 32'h1);
        check("same_ovr",   32'(bus.overrun),   32'h0);
        idle(20);

        // Reset mid-debounce clears outputs at once and drops the partial count.
        pulses(5, 4'h7, 3);
        #2 rst = 1'b1;
        #1;
        check("mrst_code",  32'(bus.key_code),  32'h00);
        check("mrst_valid", 32'(bus.key_valid), 32'h0);
        check("mrst_intr",  32'(bus.interrupt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        pulses(3, 4'h7, 3);
        check("mrst_3_valid", 32'(bus.key_valid), 32'h0);
        pulses(4, 4'h7, 3);
        check("mrst_7_valid", 32'(bus.key_valid), 32'h0);
        cyc(1'b1, 4'h7, 1'b0);
        check("mrst_8_valid", 32'(bus.key_valid), 32'h1);
        check("mrst_8_code",  32'(bus.key_code),  32'h07);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/keypad_event_port.md
KEYPAD_EVENT_PORT -- requirements
Module: keypad_event_port

Interface
REQ-001 Parameter DEB_COUNT, default 8: matching press pulses required to accept a key.
REQ-002 Parameter REL_CYCLES, default 16: consecutive clk cycles with press=0 that declare a release.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 press  input  1  key-detected strobe from the keypad scanner; at most one cycle in four while a key is held.
REQ-006 data  input  4  scanned key code; valid only when press=1.
REQ-007 key_ack  input  1  CPU read acknowledge; one-cycle pulse.
REQ-008 key_code  output  8  accepted key, {4'h0, code}, for the CPU input port.
REQ-009 key_valid  output  1  unread key present in key_code.
REQ-010 interrupt  output  1  one-cycle pulse on each new accepted key.
REQ-011 overrun  output  1  sticky flag: a key was accepted while key_valid=1.

Function
REQ-012 The block SHALL keep a gap counter: 0 on any cycle with press=1, otherwise +1, saturating at REL_CYCLES.
REQ-013 The FSM SHALL have states IDLE, DEBOUNCE, HELD.
REQ-014 IDLE: press=1 -> candidate<=data, match count<=1, go DEBOUNCE.
REQ-015 DEBOUNCE: press=1 with data==candidate -> count+1; press=1 with data!=candidate -> candidate<=data, count<=1, stay.
REQ-016 DEBOUNCE: the count reaching DEB_COUNT SHALL be the accept event; FSM goes to HELD on that edge.
REQ-017 DEBOUNCE: gap counter reaching REL_CYCLES -> IDLE, candidate discarded, no output change.
REQ-018 Gaps shorter than REL_CYCLES SHALL NOT reset the match count.
REQ-019 HELD: any press (any data) resets the gap; gap reaching REL_CYCLES -> IDLE; no further accept until IDLE is re-entered.
REQ-020 Accept with key_valid=0: key_code<={4'h0,candidate}, key_valid<=1, interrupt=1 for exactly the first cycle key_valid is high (registered, latency 1 cycle after the accepting press edge).
REQ-021 Accept with key_valid=1: key_code unchanged, overrun<=1, no interrupt.
REQ-022 key_ack=1 with key_valid=1: key_valid<=0 and overrun<=0 on the next edge.
REQ-023 key_ack with key_valid=0: ignored.
REQ-024 key_ack and accept on the same edge: the ack clears the old key, the new key is loaded, key_valid stays 1, interrupt pulses, overrun<=0.
REQ-025 key_code SHALL hold its value until the next successful accept; it is not cleared by key_ack.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, candidate=0, count=0, gap=REL_CYCLES, key_code=8'h00, key_valid=0, interrupt=0, overrun=0.
REQ-027 Reset asserted mid-DEBOUNCE or HELD SHALL discard the pending key; after release, a new key requires the full DEB_COUNT pulses.

Verification
REQ-028 data=5, press every 4th cycle, 8 pulses -> key_code=8'h05, key_valid=1, interrupt high exactly one cycle, one cycle after the 8th pulse.
REQ-029 data=5 held 200 cycles, then 20 idle cycles -> exactly one interrupt; FSM back in IDLE.
REQ-030 3 pulses data=5, then 8 pulses data=6 -> key_code=8'h06 after the 8th data=6 pulse; no interrupt for 5.
REQ-031 4 pulses data=2, 12-cycle gap, 4 pulses data=2 -> accepted (key_code=8'h02); same stimulus with a 16-cycle gap -> no accept.
REQ-032 Accept 5, no ack, release, then 8 pulses of 9 -> key_code=8'h05, overrun=1, single interrupt total; key_ack -> key_valid=0, overrun=0.
REQ-033 rst pulsed after 5 pulses of data=7 -> all outputs 0 immediately; 3 further pulses produce no accept, and 8 pulses are required.
